// File: rtl/score_pkg.sv
// Shared constants, BCD digit type and the elaboration-time BCD helper
// for the scoreboard counter.
package score_pkg;
  localparam int MAX_SCORE_DEF = 99;
  localparam int BCD_W         = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  // Packs {tens, ones} of a two-digit value.
  function automatic logic [2*BCD_W-1:0] to_bcd(input int v);
    bcd_t t, o;
    t = bcd_t'((v / 10) % 10);
    o = bcd_t'(v % 10);
    return {t, o};
  endfunction
endpackage

// File: rtl/score_channel.sv
// One score channel: input synchronisers, rising-edge detect, binary count
// with BCD digits kept in step, status flags and the change-event pulse.
module score_channel
  import score_pkg::*;
#(
  parameter int MAX_VAL     = MAX_SCORE_DEF,
  parameter int CNT_W       = 7,
  parameter int SYNC_STAGES = 2,
  parameter int WRAP_EN     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up,
  input  logic             down,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output bcd_t             tens,
  output bcd_t             ones,
  output logic             at_max,
  output logic             at_min,
  output logic             evt
);
  localparam logic [CNT_W-1:0]     MAX_C   = CNT_W'(MAX_VAL);
  localparam logic [2*BCD_W-1:0]   MAX_BCD = to_bcd(MAX_VAL);
  localparam bcd_t                 MAX_T   = MAX_BCD[2*BCD_W-1:BCD_W];
  localparam bcd_t                 MAX_O   = MAX_BCD[BCD_W-1:0];

  logic [SYNC_STAGES-1:0] up_sync, dn_sync;
  logic                   up_hist, dn_hist;
  logic                   up_edge, dn_edge;
  logic [CNT_W-1:0]       cnt_nxt;
  bcd_t                   tens_nxt, ones_nxt;

  assign up_edge = up_sync[SYNC_STAGES-1] & ~up_hist;
  assign dn_edge = dn_sync[SYNC_STAGES-1] & ~dn_hist;

  always_comb begin
    cnt_nxt  = cnt;
    tens_nxt = tens;
    ones_nxt = ones;
    if (clear) begin
      cnt_nxt  = '0;
      tens_nxt = '0;
      ones_nxt = '0;
    end else if (up_edge && !dn_edge) begin
      if (cnt < MAX_C) begin
        cnt_nxt = cnt + 1'b1;
        if (ones == 4'd9) begin
          ones_nxt = '0;
          tens_nxt = tens + 1'b1;
        end else begin
          ones_nxt = ones + 1'b1;
        end
      end else if (WRAP_EN != 0) begin
        cnt_nxt  = '0;
        tens_nxt = '0;
        ones_nxt = '0;
      end
    end else if (dn_edge && !up_edge) begin
      if (cnt != '0) begin
        cnt_nxt = cnt - 1'b1;
        if (ones == 4'd0) begin
          ones_nxt = 4'd9;
          tens_nxt = tens - 1'b1;
        end else begin
          ones_nxt = ones - 1'b1;
        end
      end else if (WRAP_EN != 0) begin
        cnt_nxt  = MAX_C;
        tens_nxt = MAX_T;
        ones_nxt = MAX_O;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_sync <= '0;
      dn_sync <= '0;
      up_hist <= 1'b0;
      dn_hist <= 1'b0;
      cnt     <= '0;
      tens    <= '0;
      ones    <= '0;
      evt     <= 1'b0;
    end else begin
      up_sync <= {up_sync[SYNC_STAGES-2:0], up};
      dn_sync <= {dn_sync[SYNC_STAGES-2:0], down};
      up_hist <= up_sync[SYNC_STAGES-1];
      dn_hist <= dn_sync[SYNC_STAGES-1];
      cnt     <= cnt_nxt;
      tens    <= tens_nxt;
      ones    <= ones_nxt;
      // Saturation, up+down collisions and clear-at-zero leave the count alone.
      evt     <= (cnt_nxt != cnt);
    end
  end

  assign at_max = (cnt == MAX_C);
  assign at_min = (cnt == '0);
endmodule

// File: rtl/score_counter.sv
// Multi-channel scoreboard counter: N_CH independent score_channel
// instances sharing clock, reset and clear, with flattened output buses.
module score_counter
  import score_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int MAX_VAL     = MAX_SCORE_DEF,
  parameter int CNT_W       = 7,
  parameter int SYNC_STAGES = 2,
  parameter int WRAP_EN     = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_CH-1:0]       up_i,
  input  logic [N_CH-1:0]       down_i,
  input  logic                  clear_i,
  output logic [N_CH*CNT_W-1:0] cnt_o,
  output logic [N_CH*BCD_W-1:0] tens_o,
  output logic [N_CH*BCD_W-1:0] ones_o,
  output logic [N_CH-1:0]       at_max_o,
  output logic [N_CH-1:0]       at_min_o,
  output logic [N_CH-1:0]       event_o
);
  if (MAX_VAL < 1 || MAX_VAL > MAX_SCORE_DEF || (2**CNT_W) <= MAX_VAL) begin : g_bad_range
    $error("score_counter: MAX_VAL out of range or CNT_W too narrow");
  end
  if (N_CH < 1 || N_CH > 4 || SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_cfg
    $error("score_counter: N_CH or SYNC_STAGES out of range");
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    score_channel #(
      .MAX_VAL    (MAX_VAL),
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES),
      .WRAP_EN    (WRAP_EN)
    ) u_ch (
      .clk   (clk_i),
      .rst_n (rst_i),
      .up    (up_i[c]),
      .down  (down_i[c]),
      .clear (clear_i),
      .cnt   (cnt_o[c*CNT_W +: CNT_W]),
      .tens  (tens_o[c*BCD_W +: BCD_W]),
      .ones  (ones_o[c*BCD_W +: BCD_W]),
      .at_max(at_max_o[c]),
      .at_min(at_min_o[c]),
      .evt   (event_o[c])
    );
  end
endmodule
